// File: rtl/noc_rr_pkg.sv
// Shared NoC router types: port encodings, lock FSM states,
// default widths and the grant-to-port decoder.
package noc_rr_pkg;

  typedef enum logic [2:0] {
    PORT_N    = 3'd0,
    PORT_S    = 3'd1,
    PORT_W    = 3'd2,
    PORT_E    = 3'd3,
    PORT_L    = 3'd4,
    PORT_NONE = 3'd7
  } port_e;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  localparam int DEF_FLIT_W       = 32;
  localparam int DEF_CREDIT_DEPTH = 4;

  // grant bits ordered {e, w, s, n}; non-one-hot maps to NONE
  function automatic port_e grant_to_port(
    input logic [3:0] gnt
  );
    port_e p;
    p = PORT_NONE;
    if ($onehot(gnt)) begin
      unique case (1'b1)
        gnt[0]:  p = PORT_N;
        gnt[1]:  p = PORT_S;
        gnt[2]:  p = PORT_W;
        gnt[3]:  p = PORT_E;
        default: p = PORT_NONE;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/l_output_credit_ctrl_if.sv
// Arbiter/crossbar/NI-facing bundle of the L output controller.
// slave = the controller, master = its environment.
interface l_output_credit_ctrl_if #(
  parameter int FLIT_W = noc_rr_pkg::DEF_FLIT_W
);

  logic              grant_n_i;
  logic              grant_s_i;
  logic              grant_w_i;
  logic              grant_e_i;
  logic [FLIT_W-1:0] xbar_flit_i;
  logic              xbar_head_i;
  logic              xbar_tail_i;
  logic              ni_credit_return_i;

  logic [FLIT_W-1:0] l_flit_o;
  logic              l_valid_o;
  logic              downstream_credit_o;
  logic              change_order_o;
  logic              locked_o;
  logic [2:0]        lock_src_o;
  logic              err_o;

  modport slave (
    input  grant_n_i,
    input  grant_s_i,
    input  grant_w_i,
    input  grant_e_i,
    input  xbar_flit_i,
    input  xbar_head_i,
    input  xbar_tail_i,
    input  ni_credit_return_i,
    output l_flit_o,
    output l_valid_o,
    output downstream_credit_o,
    output change_order_o,
    output locked_o,
    output lock_src_o,
    output err_o
  );

  modport master (
    output grant_n_i,
    output grant_s_i,
    output grant_w_i,
    output grant_e_i,
    output xbar_flit_i,
    output xbar_head_i,
    output xbar_tail_i,
    output ni_credit_return_i,
    input  l_flit_o,
    input  l_valid_o,
    input  downstream_credit_o,
    input  change_order_o,
    input  locked_o,
    input  lock_src_o,
    input  err_o
  );

endinterface

// File: rtl/noc_credit_counter.sv
// Saturating downstream credit counter, reset to full depth.
// Shared by all router output controllers.
module noc_credit_counter
  import noc_rr_pkg::*;
#(
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dec,
  input  logic i_inc,
  output logic [$clog2(CREDIT_DEPTH+1)-1:0] o_count,
  output logic o_nonzero,
  output logic o_overflow
);

  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(CREDIT_DEPTH);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == MAX);
  assign w_at_zero = (r_count == '0);

  // simultaneous inc and dec cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= MAX;
    end else if (i_dec && !i_inc && !w_at_zero) begin
      r_count <= r_count - 1'b1;
    end else if (i_inc && !i_dec && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_nonzero  = !w_at_zero;
  assign o_overflow = i_inc && !i_dec && w_at_max;

endmodule

// File: rtl/l_output_credit_ctrl.sv
// L output port controller: flit register, credits, packet lock.
// Optional L_CREDIT_EARLY_RETURN_EN lets a same-cycle NI return act as credit.
module l_output_credit_ctrl
  import noc_rr_pkg::*;
#(
  parameter int FLIT_W       = DEF_FLIT_W,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH
) (
  input  logic clk,
  input  logic reset,
  l_output_credit_ctrl_if.slave io
);

  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);

  localparam logic [0:0] S_IDLE   = LOCK_IDLE;
  localparam logic [0:0] S_LOCKED = LOCK_LOCKED;

  logic [FLIT_W-1:0] r_flit;
  logic              r_valid;
  logic              r_chg;
  logic [0:0]        r_state;
  port_e             r_lock_src;
  logic              r_err;

  logic [3:0]        w_gnt;
  logic              w_any;
  logic              w_one;
  port_e             w_src;
  logic              w_legal;
  logic              w_early_ret;
  logic              w_credit_ok;
  logic              w_send;
  logic              w_head_err;
  logic              w_err_set;
  logic [CNT_W-1:0]  w_count;
  logic              w_nonzero;
  logic              w_overflow;
  logic              w_at_zero;
  logic [0:0]        w_state_nxt;
  port_e             w_src_nxt;
  logic              w_chg;

  noc_credit_counter #(
    .CREDIT_DEPTH (CREDIT_DEPTH)
  ) u_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_dec      (w_send),
    .i_inc      (io.ni_credit_return_i),
    .o_count    (w_count),
    .o_nonzero  (w_nonzero),
    .o_overflow (w_overflow)
  );

  assign w_gnt = {io.grant_e_i, io.grant_w_i,
                  io.grant_s_i, io.grant_n_i};
  assign w_any = |w_gnt;
  assign w_one = $onehot(w_gnt);
  assign w_src = grant_to_port(w_gnt);

  assign w_legal = (r_state == S_IDLE) ||
                   (w_src == r_lock_src);

`ifdef L_CREDIT_EARLY_RETURN_EN
  assign w_early_ret = io.ni_credit_return_i;
`else
  assign w_early_ret = 1'b0;
`endif

  assign w_at_zero   = (w_count == '0);
  assign w_credit_ok = w_nonzero || w_early_ret;
  assign w_send      = w_one && w_legal && w_credit_ok;

  // a headless flit in IDLE is still forwarded, only flagged
  assign w_head_err = w_send && (r_state == S_IDLE) &&
                      !io.xbar_head_i;

  assign w_err_set = (w_any && !w_one) ||
                     (w_one && !w_legal) ||
                     (w_one && w_at_zero && !w_early_ret) ||
                     w_head_err ||
                     w_overflow;

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_lock_src;
    w_chg       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_send && io.xbar_head_i) begin
          if (io.xbar_tail_i) begin
            w_chg = 1'b1;
          end else begin
            w_state_nxt = S_LOCKED;
            w_src_nxt   = w_src;
          end
        end
      end
      S_LOCKED: begin
        if (w_send && io.xbar_tail_i) begin
          w_state_nxt = S_IDLE;
          w_src_nxt   = PORT_NONE;
          w_chg       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_src_nxt   = PORT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flit     <= '0;
      r_valid    <= 1'b0;
      r_chg      <= 1'b0;
      r_state    <= S_IDLE;
      r_lock_src <= PORT_NONE;
      r_err      <= 1'b0;
    end else begin
      r_valid    <= w_send;
      r_chg      <= w_chg;
      r_state    <= w_state_nxt;
      r_lock_src <= w_src_nxt;
      r_err      <= r_err || w_err_set;
      if (w_send) begin
        r_flit <= io.xbar_flit_i;
      end
    end
  end

  assign io.l_flit_o            = r_flit;
  assign io.l_valid_o           = r_valid;
  assign io.change_order_o      = r_chg;
  assign io.locked_o            = (r_state == S_LOCKED);
  assign io.lock_src_o          = r_lock_src;
  assign io.err_o               = r_err;
  assign io.downstream_credit_o = w_credit_ok;

endmodule

// File: tb/tb_l_output_credit_ctrl.sv
// Scoreboard bench for l_output_credit_ctrl: a spec-level model
// pushes expected outputs per driven cycle; tasks pop and compare.
module tb_l_output_credit_ctrl;
  import noc_rr_pkg::*;

  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic          v;
    logic [FW-1:0] f;
    logic          c;
    logic          lk;
    logic [2:0]    src;
    logic          e;
    logic          cr;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct {
    logic [3:0]    g;
    logic [FW-1:0] f;
    logic          h;
    logic          t;
    logic          r;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l_output_credit_ctrl_if #(.FLIT_W(FW)) io();

  l_output_credit_ctrl #(
    .FLIT_W       (FW),
    .CREDIT_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;
  obs_t sb[$];

  int            m_cnt;
  bit            m_lock;
  logic [2:0]    m_src;
  bit            m_err;
  logic [FW-1:0] m_flit;

  obs_t R_EXP;

  function automatic obs_t sample();
    obs_t o;
    o.v   = io.l_valid_o;
    o.f   = io.l_flit_o;
    o.c   = io.change_order_o;
    o.lk  = io.locked_o;
    o.src = io.lock_src_o;
    o.e   = io.err_o;
    o.cr  = io.downstream_credit_o;
    o.cnt = dut.u_cnt.r_count;
    return o;
  endfunction

  task automatic idle_inputs();
    io.grant_n_i          = 1'b0;
    io.grant_s_i          = 1'b0;
    io.grant_w_i          = 1'b0;
    io.grant_e_i          = 1'b0;
    io.xbar_flit_i        = '0;
    io.xbar_head_i        = 1'b0;
    io.xbar_tail_i        = 1'b0;
    io.ni_credit_return_i = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt  = DEPTH;
    m_lock = 1'b0;
    m_src  = 3'd7;
    m_err  = 1'b0;
    m_flit = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_reset();
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    int         ng;
    logic [2:0] gs;
    bit         credok, legal, send, chg, eset;
    obs_t       x;
    @(negedge clk);
    io.grant_n_i          = s.g[0];
    io.grant_s_i          = s.g[1];
    io.grant_w_i          = s.g[2];
    io.grant_e_i          = s.g[3];
    io.xbar_flit_i        = s.f;
    io.xbar_head_i        = s.h;
    io.xbar_tail_i        = s.t;
    io.ni_credit_return_i = s.r;
    ng = $countones(s.g);
    gs = 3'd7;
    for (int i = 0; i < 4; i++) if (s.g[i]) gs = 3'(i);
    credok = (m_cnt != 0);
`ifdef L_CREDIT_EARLY_RETURN_EN
    credok = credok || s.r;
`endif
    legal = !m_lock || (gs == m_src);
    send  = (ng == 1) && credok && legal;
    chg   = send && s.t && (m_lock || s.h);
    eset  = (ng > 1) || ((ng == 1) && !send) ||
            (send && !m_lock && !s.h) ||
            (s.r && !send && (m_cnt == DEPTH));
    m_err = m_err || eset;
    if (send) m_flit = s.f;
    if (!m_lock && send && s.h && !s.t) begin
      m_lock = 1'b1;
      m_src  = gs;
    end else if (m_lock && send && s.t) begin
      m_lock = 1'b0;
      m_src  = 3'd7;
    end
    if (send && !s.r) m_cnt = m_cnt - 1;
    else if (s.r && !send && m_cnt < DEPTH) m_cnt = m_cnt + 1;
    x.v = send; x.f = m_flit; x.c = chg; x.lk = m_lock;
    x.src = m_src; x.e = m_err; x.cr = (m_cnt != 0);
    x.cnt = CW'(m_cnt);
    sb.push_back(x);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    obs_t got;
    do_reset();
    #1;
    got = sample();
    checks++;
    if (got !== R_EXP) begin
      errors++;
      $display("FAIL reset: got %h expected %h", got, R_EXP);
    end
  endtask

  task automatic test_single_flit();
    stim_t tab [2];
    obs_t  got, exp;
    do_reset();
    tab = '{'{4'b1000, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      drive(tab[i]);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_locked_packet();
    stim_t tab [6];
    obs_t  got, exp;
    do_reset();
    tab = '{'{4'b0001, 32'h11110000, 1'b1, 1'b0, 1'b0},
            '{4'b0001, 32'h11110001, 1'b0, 1'b0, 1'b0},
            '{4'b0010, 32'h22220000, 1'b1, 1'b1, 1'b0},
            '{4'b0001, 32'h11110002, 1'b0, 1'b0, 1'b0},
            '{4'b0001, 32'h11110003, 1'b0, 1'b1, 1'b0},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      drive(tab[i]);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL locked[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t tab [7];
    obs_t  got, exp;
    do_reset();
    tab = '{'{4'b0001, 32'hB0000001, 1'b1, 1'b1, 1'b0},
            '{4'b0010, 32'hB0000002, 1'b1, 1'b1, 1'b0},
            '{4'b0100, 32'hB0000003, 1'b1, 1'b1, 1'b0},
            '{4'b1000, 32'hB0000004, 1'b1, 1'b1, 1'b0},
            '{4'b0001, 32'hB0000005, 1'b1, 1'b1, 1'b0},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b1},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      drive(tab[i]);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 3) begin
        checks++;
        if (got.cr !== 1'b0) begin
          errors++;
          $display("FAIL b2b_empty: credit %b expected 0", got.cr);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    stim_t tab [7];
    obs_t  got, exp;
    do_reset();
    tab = '{'{4'b0100, 32'hC0000001, 1'b1, 1'b1, 1'b0},
            '{4'b0100, 32'hC0000002, 1'b1, 1'b1, 1'b0},
            '{4'b0100, 32'hC0000003, 1'b1, 1'b1, 1'b1},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b1},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b1},
            '{4'b0000, 32'h0, 1'b0, 1'b0, 1'b1},
            '{4'b0011, 32'hC0000004, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      drive(tab[i]);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL same[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_locked();
    stim_t tab [3];
    obs_t  got, exp;
    do_reset();
    tab = '{'{4'b0100, 32'hD0000000, 1'b1, 1'b0, 1'b0},
            '{4'b0100, 32'hD0000001, 1'b0, 1'b0, 1'b0},
            '{4'b0100, 32'hD0000002, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(tab[i]);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rlock[%0d]: got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    got = sample();
    model_reset();
    checks++;
    if (got !== R_EXP) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", got, R_EXP);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    stim_t s;
    obs_t  got, exp;
    int    k;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) s.g = 4'b0000;
      else if (k == 1) s.g = 4'($urandom_range(0, 15));
      else if (m_lock && k < 7) s.g = 4'(1 << m_src);
      else s.g = 4'(1 << $urandom_range(0, 3));
      s.f = 32'($urandom);
      s.h = 1'($urandom_range(0, 1));
      s.t = 1'($urandom_range(0, 1));
      s.r = ($urandom_range(0, 3) == 0);
      drive(s);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    R_EXP = '{v: 1'b0, f: '0, c: 1'b0, lk: 1'b0, src: 3'd7,
              e: 1'b0, cr: 1'b1, cnt: CW'(DEPTH)};
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_flit();
    test_locked_packet();
    test_back_to_back();
    test_same_cycle();
    test_reset_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
